// File: rtl/sched_pkg.sv
// Shared request-format constants and state type for the scheduler request queue.
package sched_pkg;

  localparam int REQ_W     = 68;
  localparam int ROW_LSB   = 48;
  localparam int ROW_W     = 16;
  localparam int VALID_BIT = REQ_W - 1;
  localparam int ROW_MSB   = ROW_LSB + ROW_W - 1;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sched_batch_len.sv
// First-invalid priority encoder: batch length is the index of the first
// entry whose valid bit is clear, or DEPTH when every entry is valid.
module sched_batch_len
  import sched_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic [DEPTH-1:0] valid,
  output logic [LEN_W-1:0] len
);

  // Scanning downwards lets the lowest clear bit win.
  always_comb begin
    len = LEN_W'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) len = LEN_W'(i);
    end
  end

endmodule

// File: rtl/sched_request_queue.sv
// Batch queue between request scheduler and command generator, with hold-off
// rate limiting. Row lookahead is built only when SCHED_QUEUE_LOOKAHEAD_EN is defined.
module sched_request_queue
  import sched_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DEPTH*REQ_W-1:0]   load_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     ext_load,
  output logic                     req_valid,
  output logic [REQ_W-1:0]         req_data,
  input  logic                     req_ready,
  output logic [ROW_W-1:0]         next_row,
  output logic                     next_row_valid,
  output logic [$clog2(DEPTH):0]   remaining
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(HOLDOFF + 1);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   len_reg;
  logic [PTR_W-1:0]   load_len;
  logic [CNT_W-1:0]   cnt_reg;
  logic [REQ_W-1:0]   entries_reg [DEPTH];
  logic [DEPTH-1:0]   load_valid_bits;
  logic               fire;
  logic               last_fire;
  logic               cnt_full;
  logic               cap;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign load_valid_bits[gi] = load_data[gi*REQ_W + VALID_BIT];

      always_ff @(posedge clk) begin
        if (reset) begin
          entries_reg[gi] <= '0;
        end else if (cap) begin
          entries_reg[gi] <= load_data[gi*REQ_W +: REQ_W];
        end
      end
    end
  endgenerate

  sched_batch_len #(.DEPTH(DEPTH)) u_batch_len (
    .valid (load_valid_bits),
    .len   (load_len)
  );

  assign req_valid  = (state_reg == ACTIVE);
  assign fire       = req_valid & req_ready;
  assign last_fire  = fire & (ptr_reg == len_reg - PTR_W'(1));
  assign cnt_full   = (cnt_reg == CNT_W'(HOLDOFF));
  // Combinational from req_ready so a final handshake and a reload share a cycle.
  assign load_ready = cnt_full & ((state_reg == EMPTY) | last_fire);
  assign cap        = load_valid & (ext_load | load_ready);

  always_comb begin
    state_next = state_reg;
    if (cap) begin
      state_next = (load_len != '0) ? ACTIVE : EMPTY;
    end else if (last_fire) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
      len_reg <= '0;
      cnt_reg <= CNT_W'(HOLDOFF);
    end else if (cap) begin
      ptr_reg <= '0;
      len_reg <= load_len;
      cnt_reg <= '0;
    end else begin
      if (fire)      ptr_reg <= ptr_reg + PTR_W'(1);
      if (!cnt_full) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // ptr stays below len while ACTIVE, so the low bits always address a live entry.
  assign req_data  = req_valid ? entries_reg[ptr_reg[IDX_W-1:0]] : '0;
  assign remaining = req_valid ? (len_reg - ptr_reg) : '0;

`ifdef SCHED_QUEUE_LOOKAHEAD_EN
  logic [PTR_W-1:0] nxt_ptr;

  assign nxt_ptr        = ptr_reg + PTR_W'(1);
  assign next_row_valid = req_valid & (nxt_ptr < len_reg);
  assign next_row       = next_row_valid ? entries_reg[nxt_ptr[IDX_W-1:0]][ROW_LSB +: ROW_W] : '0;
`else
  assign next_row       = '0;
  assign next_row_valid = 1'b0;
`endif

endmodule
